// File: rtl/regfile_read_port.sv
// Read side of the register file: two-operand read requests with write-port bypass,
// returned in order through a two-entry response buffer over valid/ready.
module regfile_read_port #(
   parameter int WIDTH    = 64,
   parameter int NREGS    = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 31,
   parameter int DEPTH    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREGS*WIDTH-1:0] regs_flat,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [AW-1:0]          req_ra,
   input  logic [AW-1:0]          req_rb,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       rsp_da,
   output logic [WIDTH-1:0]       rsp_db
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [1:0]       count;
   logic             rd_ptr;
   logic             wr_ptr;
   logic             accept;
   logic             pop;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   assign req_ready = reset && (count < 2'd2);
   assign rsp_valid = (count != 2'd0);
   assign accept    = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;

   // The bank captures a write on the same edge we sample it, so a matching write
   // is forwarded; the zero register wins over that forward.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      op_a = regs_flat[req_ra*WIDTH +: WIDTH];
      op_b = regs_flat[req_rb*WIDTH +: WIDTH];
      if (wr_en && (wr_addr == req_ra)) op_a = wr_data;
      if (wr_en && (wr_addr == req_rb)) op_b = wr_data;
      if (req_ra == ZERO_IDX) op_a = '0;
      if (req_rb == ZERO_IDX) op_b = '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (accept) wr_ptr <= ~wr_ptr;
         if (pop)    rd_ptr <= ~rd_ptr;
         case ({accept, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: buffer storage is deliberately not reset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_a[wr_ptr] <= op_a;
         mem_b[wr_ptr] <= op_b;
      end
   end

   // Head entry drives the outputs; an empty buffer presents zeros.
   assign rsp_da = rsp_valid ? mem_a[rd_ptr] : '0;
   assign rsp_db = rsp_valid ? mem_b[rd_ptr] : '0;

endmodule

// File: tb/tb_regfile_read_port.sv
// Self-checking bench for regfile_read_port: directed vector table, streaming run,
// then randomized traffic scored against a queue-based reference model.
module tb_regfile_read_port;

   localparam int WIDTH = 64;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   typedef struct {
      logic             rst;
      logic             rv;
      logic [AW-1:0]    ra;
      logic [AW-1:0]    rb;
      logic             we;
      logic [AW-1:0]    wa;
      logic [WIDTH-1:0] wd;
      logic             rr;
      logic             e_ready;
      logic             e_valid;
      logic [WIDTH-1:0] e_da;
      logic [WIDTH-1:0] e_db;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } rsp_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NREGS*WIDTH-1:0] regs_flat;
   logic                   wr_en;
   logic [AW-1:0]          wr_addr;
   logic [WIDTH-1:0]       wr_data;
   logic                   req_valid;
   logic                   req_ready;
   logic [AW-1:0]          req_ra;
   logic [AW-1:0]          req_rb;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [WIDTH-1:0]       rsp_da;
   logic [WIDTH-1:0]       rsp_db;

   logic [WIDTH-1:0] reg_m [NREGS];
   rsp_t             exp_q [$];
   int               errors = 0;
   int               checks = 0;

   always #5 clk = ~clk;

   regfile_read_port dut (
      .clk(clk), .reset(reset), .regs_flat(regs_flat),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .req_valid(req_valid), .req_ready(req_ready), .req_ra(req_ra), .req_rb(req_rb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_da(rsp_da), .rsp_db(rsp_db)
   );

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic rv, input int ra, input int rb,
                               input logic we, input int wa, input logic [WIDTH-1:0] wd,
                               input logic rr, input logic e_ready, input logic e_valid,
                               input logic [WIDTH-1:0] e_da, input logic [WIDTH-1:0] e_db);
      vec_t v;
      v.rst = rst; v.rv = rv; v.ra = AW'(ra); v.rb = AW'(rb);
      v.we = we; v.wa = AW'(wa); v.wd = wd; v.rr = rr;
      v.e_ready = e_ready; v.e_valid = e_valid; v.e_da = e_da; v.e_db = e_db;
      return v;
   endfunction

   // Value the architecture says a read of r returns while a given write is in flight.
   function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] r, input logic we,
                                                   input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd);
      if (r == AW'(31)) return '0;
      if (we && wa == r) return wd;
      return reg_m[r];
   endfunction

   // One clock: drive, check ready, advance the model, clock, check outputs.
   task automatic run_cycle(input logic use_tbl, input vec_t v);
      logic  m_ready;
      rsp_t  e;
      reset = v.rst; req_valid = v.rv; req_ra = v.ra; req_rb = v.rb;
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; rsp_ready = v.rr;
      for (int i = 0; i < NREGS; i++) regs_flat[i*WIDTH +: WIDTH] = reg_m[i];
      #1;
      m_ready = v.rst && (exp_q.size() < 2);
      check("req_ready_model", {63'd0, req_ready}, {63'd0, m_ready});
      if (use_tbl) check("req_ready_tbl", {63'd0, req_ready}, {63'd0, v.e_ready});
      if (!v.rst) exp_q.delete();
      else begin
         if (exp_q.size() != 0 && v.rr) void'(exp_q.pop_front());
         if (m_ready && v.rv) begin
            e.a = model_read(v.ra, v.we, v.wa, v.wd);
            e.b = model_read(v.rb, v.we, v.wa, v.wd);
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      if (v.we) reg_m[v.wa] = v.wd;
      #1;
      check("rsp_valid_model", {63'd0, rsp_valid}, {63'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
         check("rsp_da_model", rsp_da, exp_q[0].a);
         check("rsp_db_model", rsp_db, exp_q[0].b);
      end else if (!v.rst) begin
         check("rsp_da_reset", rsp_da, '0);
         check("rsp_db_reset", rsp_db, '0);
      end
      if (use_tbl) begin
         check("rsp_valid_tbl", {63'd0, rsp_valid}, {63'd0, v.e_valid});
         if (v.e_valid || !v.rst) begin
            check("rsp_da_tbl", rsp_da, v.e_da);
            check("rsp_db_tbl", rsp_db, v.e_db);
         end
      end
   endtask

   vec_t tbl [19];
   vec_t v;

   initial begin
      for (int i = 0; i < NREGS; i++) reg_m[i] = WIDTH'(i) * 64'h11;
      reg_m[5]  = '0;
      reg_m[31] = '1;

      //        rst rv ra rb we wa wd            rr rdy val da            db
      tbl[0]  = mk(0, 1, 1, 2, 0, 0, 0,            0, 0, 0, 0,            0);
      tbl[1]  = mk(0, 1, 1, 2, 0, 0, 0,            0, 0, 0, 0,            0);
      tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0,            1, 1, 0, 0,            0);
      tbl[3]  = mk(1, 1, 1, 2, 0, 0, 0,            1, 1, 1, 64'h11,       64'h22);
      tbl[4]  = mk(1, 1, 5, 2, 1, 5, 64'hDEAD,     1, 1, 1, 64'hDEAD,     64'h22);
      tbl[5]  = mk(1, 1, 31, 5, 1, 31, 64'hBEEF,   1, 1, 1, 0,            64'hDEAD);
      tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0,            1, 1, 0, 0,            0);
      tbl[7]  = mk(1, 1, 1, 2, 0, 0, 0,            0, 1, 1, 64'h11,       64'h22);
      tbl[8]  = mk(1, 1, 2, 3, 0, 0, 0,            0, 1, 1, 64'h11,       64'h22);
      tbl[9]  = mk(1, 1, 3, 1, 0, 0, 0,            0, 0, 1, 64'h11,       64'h22);
      tbl[10] = mk(1, 1, 3, 1, 0, 0, 0,            0, 0, 1, 64'h11,       64'h22);
      tbl[11] = mk(1, 1, 3, 1, 0, 0, 0,            1, 0, 1, 64'h22,       64'h33);
      tbl[12] = mk(1, 1, 3, 1, 0, 0, 0,            1, 1, 1, 64'h33,       64'h11);
      tbl[13] = mk(1, 0, 0, 0, 0, 0, 0,            1, 1, 0, 0,            0);
      tbl[14] = mk(1, 1, 1, 2, 0, 0, 0,            0, 1, 1, 64'h11,       64'h22);
      tbl[15] = mk(1, 1, 2, 3, 0, 0, 0,            0, 1, 1, 64'h11,       64'h22);
      tbl[16] = mk(0, 1, 3, 1, 0, 0, 0,            0, 0, 0, 0,            0);
      tbl[17] = mk(1, 1, 7, 8, 0, 0, 0,            1, 1, 1, 64'h77,       64'h88);
      tbl[18] = mk(1, 0, 0, 0, 0, 0, 0,            1, 1, 0, 0,            0);

      for (int i = 0; i < 19; i++) run_cycle(1'b1, tbl[i]);

      // Streaming: one request per cycle with the consumer always ready.
      for (int i = 0; i < 8; i++) begin
         v = mk(1, 1, i + 1, 8 - i, 0, 0, 0, 1, 1, 1, 0, 0);
         run_cycle(1'b0, v);
         check("stream_valid", {63'd0, rsp_valid}, 64'd1);
      end

      // Randomized traffic, biased toward the zero register and bypass hits.
      for (int n = 0; n < 600; n++) begin
         v = mk(($urandom_range(0, 39) != 0), $urandom_range(0, 1),
                ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 31),
                ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 31),
                $urandom_range(0, 1), 0, {$urandom, $urandom},
                ($urandom_range(0, 2) != 0), 0, 0, 0, 0);
         v.wa = ($urandom_range(0, 2) == 0) ? v.ra : AW'($urandom_range(0, 31));
         run_cycle(1'b0, v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read side of the CPU register file; the write side is the bank of enabled D flip-flops.
- Takes read requests for two register numbers and returns both operand values in order over a valid/ready stream.
- The write port's enable, address and data are observed so a read issued in the same cycle as a write returns the newly written value.
- Sits between the flattened register-bank outputs and the decode/operand-fetch stage.

Parameters:
WIDTH  64  data width of one register
NREGS  32  number of architectural registers
AW  5  register-address width, equal to clog2(NREGS)
ZERO_REG  31  register index that always reads as 0
DEPTH  2  response buffer entries (fixed at 2)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
regs_flat  in  NREGS*WIDTH  current register contents; register i is at bits [i*WIDTH +: WIDTH]
wr_en  in  1  write-port enable for this cycle (same signal that drives the bank's D_FF enables)
wr_addr  in  AW  write-port register number
wr_data  in  WIDTH  write-port data
req_valid  in  1  read request present
req_ready  out  1  read request can be accepted
req_ra  in  AW  first source register
req_rb  in  AW  second source register
rsp_valid  out  1  response at head of buffer
rsp_ready  in  1  consumer accepts response
rsp_da  out  WIDTH  value of req_ra
rsp_db  out  WIDTH  value of req_rb

Behaviour:
- Reset: sampled at posedge clk when reset==0. Clears count, read pointer and write pointer. rsp_valid=0, rsp_da=0, rsp_db=0 at the first edge where reset is low. req_ready=0 while reset==0. Buffer contents are don't-care.
- Reset mid-operation: all buffered responses are discarded, nothing is replayed, and the block is not stalled.
- Accept: req_valid && req_ready at posedge. Pop: rsp_valid && rsp_ready at posedge.
- req_ready = reset && (count < 2). It depends only on state; there is no combinational path from rsp_ready.
- rsp_valid = (count != 0). rsp_da and rsp_db are driven from the head entry, so they are registered outputs.
- Operand value, computed at the accept edge for each of ra and rb:
  - If addr == ZERO_REG: 0. This overrides the bypass, even when wr_en && wr_addr == ZERO_REG.
  - Else if wr_en && wr_addr == addr: wr_data (bypass, because the bank updates on the same edge).
  - Else: regs_flat slice for addr.
- Latency: a request accepted at edge N is visible on rsp_* after edge N when the buffer was empty. Otherwise it waits behind older entries.
- Ordering: strict FIFO; responses are returned in request order.
- Count update:
  - accept only: +1
  - pop only: -1
  - accept and pop in the same cycle (count==1 only): count unchanged, head advances, new entry written
  - neither: hold
- Boundaries:
  - count==2: req_ready=0, so no accept is possible.
  - count==0: rsp_valid=0; rsp_ready is ignored.
  - Pointers are 1 bit and wrap modulo 2.
- Stall: while rsp_valid && !rsp_ready, rsp_da and rsp_db hold stable.
- Buffered entries are snapshots. Writes after acceptance do not modify them; no re-bypass is applied.
- Addresses are always in range; there is no error output.

Test Plan:
- Reset: reset=0 for 2 cycles with req_valid=1 -> rsp_valid=0, rsp_da=0, rsp_db=0, req_ready=0, no accept. Release reset -> req_ready=1 next cycle.
- Basic read: regs X1=0x11, X2=0x22; request ra=1, rb=2 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_da=0x11, rsp_db=0x22.
- Bypass:
  - Request ra=5 in the same cycle as wr_en=1, wr_addr=5, wr_data=0xDEAD, with X5 previously 0x0 -> rsp_da=0xDEAD.
  - Repeat with wr_addr=31 and ra=31 -> rsp_da=0.
- Backpressure: rsp_ready=0, issue 3 back-to-back requests (ra=1,2,3) -> first 2 accepted, req_ready=0 on the 3rd. rsp_da holds 0x11 until rsp_ready=1, then returns 0x11, 0x22, 0x33 in order; the 3rd request is accepted once count<2.
- Simultaneous accept and pop at count==1 -> count stays 1. Continuous streaming of 8 requests with rsp_ready=1 gives one response per cycle, in order.
- Mid-operation reset: two buffered responses, then reset=0 for one cycle -> rsp_valid=0. After release, a new request returns fresh data and no stale entry appears.
